// File: rtl/obuft_sched_pkg.sv
// obuft_sched_pkg: shared state encoding and width helpers for the OBUFT bus scheduler.
// Contents:
//   state_e            FSM encoding, IDLE=0 DRIVE=1 TURN=2
//   DEF_TURN_CYC       default high-Z gap between owners
//   DEF_MAX_HOLD       default drive cycles before preemption
//   clog2(n)           bits needed to index n items
//   cnt_w(n)           bits needed to hold values 0..n
package obuft_sched_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, TURN = 2'd2} state_e;
   localparam int DEF_TURN_CYC = 2;
   localparam int DEF_MAX_HOLD = 16;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
   function automatic int cnt_w(input int n);
      return clog2(n + 1);
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports:
//   req     in   NREQ  request vector
//   ptr     in   PW    search start index
//   any     out  1     some request is set
//   idx     out  PW    first set request at or after ptr, wrapping
//   onehot  out  NREQ  one-hot form of idx, zero when no request
module rr_pick
   import obuft_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PW   = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic            any,
   output logic [PW-1:0]   idx,
   output logic [NREQ-1:0] onehot
);
   // Scanning from the far end downward lets the nearest hit overwrite the rest.
   always_comb begin
      idx = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (req[(int'(ptr) + i) % NREQ]) idx = PW'((int'(ptr) + i) % NREQ);
      any = |req;
      onehot = any ? NREQ'(1) << idx : '0;
   end
endmodule

// File: rtl/obuft_bus_sched.sv
// obuft_bus_sched: round-robin time-sharing of one OBUFT bus with a high-Z turnaround gap.
// Ports:
//   CLK    in   1           rising-edge clock
//   RSTN   in   1           synchronous active-low reset
//   REQ    in   NREQ        level-sensitive bus requests
//   DIN    in   NREQ*WIDTH  requester data, slice k = DIN[k*WIDTH +: WIDTH]
//   GNT    out  NREQ        registered one-hot grant
//   BUS_I  out  WIDTH       registered OBUFT I pins
//   BUS_T  out  WIDTH       registered OBUFT T pins, 1 = high-Z
//   OWNER  out  clog2(NREQ) current owner, valid while BUSY
//   BUSY   out  1           some grant is active
module obuft_bus_sched
   import obuft_sched_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 8,
   parameter int TURN_CYC = DEF_TURN_CYC,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic                    CLK,
   input  logic                    RSTN,
   input  logic [NREQ-1:0]         REQ,
   input  logic [NREQ*WIDTH-1:0]   DIN,
   output logic [NREQ-1:0]         GNT,
   output logic [WIDTH-1:0]        BUS_I,
   output logic [WIDTH-1:0]        BUS_T,
   output logic [clog2(NREQ)-1:0]  OWNER,
   output logic                    BUSY
);
   localparam int PW = clog2(NREQ);
   localparam int TW = cnt_w(TURN_CYC);
   localparam int HW = cnt_w(MAX_HOLD);
   state_e            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d, owner_q, owner_d;
   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [WIDTH-1:0]  bus_i_q, bus_i_d, bus_t_q, bus_t_d;
   logic              pick_any, arb, rel;
   logic [PW-1:0]     pick_idx;
   logic [NREQ-1:0]   pick_oh;
   rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req    (REQ),
      .ptr    (ptr_q),
      .any    (pick_any),
      .idx    (pick_idx),
      .onehot (pick_oh)
   );
   // gnt_q is one-hot on the owner, so it doubles as the owner mask for release.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      tcnt_d  = tcnt_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      bus_i_d = bus_i_q;
      bus_t_d = bus_t_q;
      arb = state_q == IDLE || (state_q == TURN && tcnt_q == TW'(TURN_CYC - 1));
      rel = !(|(REQ & gnt_q)) || (hold_q == HW'(MAX_HOLD) && |(REQ & ~gnt_q));
      if (state_q == DRIVE) begin
         if (rel) begin
            state_d = TURN;
            gnt_d   = '0;
            bus_t_d = '1;
            bus_i_d = '0;
            tcnt_d  = '0;
            ptr_d   = owner_q == PW'(NREQ - 1) ? '0 : owner_q + PW'(1);
         end else begin
            bus_i_d = DIN[owner_q*WIDTH +: WIDTH];
            hold_d  = hold_q == HW'(MAX_HOLD) ? hold_q : hold_q + HW'(1);
         end
      end else if (arb) begin
         state_d = pick_any ? DRIVE : IDLE;
         if (pick_any) begin
            gnt_d   = pick_oh;
            owner_d = pick_idx;
            bus_t_d = '0;
            bus_i_d = DIN[pick_idx*WIDTH +: WIDTH];
            hold_d  = HW'(1);
         end
      end else begin
         tcnt_d = tcnt_q + TW'(1);
      end
   end
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         tcnt_q  <= '0;
         hold_q  <= '0;
         gnt_q   <= '0;
         bus_i_q <= '0;
         bus_t_q <= '1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         tcnt_q  <= tcnt_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         bus_i_q <= bus_i_d;
         bus_t_q <= bus_t_d;
      end
   end
   assign GNT   = gnt_q;
   assign BUS_I = bus_i_q;
   assign BUS_T = bus_t_q;
   assign OWNER = owner_q;
   assign BUSY  = |gnt_q;
endmodule

// File: tb/tb_obuft_bus_sched.sv
// tb_obuft_bus_sched: directed bench with a per-cycle reference model for two scheduler instances.
module tb_obuft_bus_sched;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int TC = 2;
   typedef struct packed {
      int own;
      int ptr;
      int hold;
      int gap;
      logic [7:0] bi;
   } mdl_t;
   logic CLK = 1'b0;
   logic RSTN;
   logic [N-1:0] REQ;
   logic [N*W-1:0] DIN;
   logic [N-1:0] g0, g1;
   logic [W-1:0] i0, i1, t0, t1;
   logic [1:0] o0, o1;
   logic b0, b1;
   int errors = 0;
   int checks = 0;
   logic chk_en = 1'b0;
   mdl_t m0, m1;
   always #5 CLK = ~CLK;
   obuft_bus_sched #(.NREQ(N), .WIDTH(W), .TURN_CYC(TC), .MAX_HOLD(16)) u0 (
      .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .DIN(DIN),
      .GNT(g0), .BUS_I(i0), .BUS_T(t0), .OWNER(o0), .BUSY(b0)
   );
   obuft_bus_sched #(.NREQ(N), .WIDTH(W), .TURN_CYC(TC), .MAX_HOLD(1)) u1 (
      .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .DIN(DIN),
      .GNT(g1), .BUS_I(i1), .BUS_T(t1), .OWNER(o1), .BUSY(b1)
   );
   // Model: own=-1 means no owner; gap counts remaining high-Z cycles before a new pick.
   function automatic mdl_t step(mdl_t m, logic rst_n, logic [N-1:0] req, logic [N*W-1:0] din, int mh);
      mdl_t n;
      n = m;
      if (!rst_n) begin
         n.own = -1; n.ptr = 0; n.hold = 0; n.gap = 0; n.bi = '0;
      end else if (m.own >= 0) begin
         if (!req[m.own] || (m.hold == mh && (req & ~(4'b0001 << m.own)) != 0)) begin
            n.own = -1; n.ptr = (m.own + 1) % N; n.gap = TC; n.bi = '0;
         end else begin
            n.bi = din[m.own*W +: W];
            n.hold = (m.hold < mh) ? m.hold + 1 : mh;
         end
      end else if (m.gap > 1) begin
         n.gap = m.gap - 1;
      end else begin
         n.gap = 0;
         for (int i = 0; i < N; i++)
            if (n.own < 0 && req[(m.ptr + i) % N]) n.own = (m.ptr + i) % N;
         if (n.own >= 0) begin
            n.hold = 1;
            n.bi = din[n.own*W +: W];
         end
      end
      return n;
   endfunction
   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask
   task automatic chk_dut(input string p, input mdl_t m, input logic [N-1:0] g, input logic [W-1:0] bi,
                          input logic [W-1:0] bt, input logic [1:0] o, input logic b);
      cmp({p, ".gnt"}, 32'(g), m.own >= 0 ? 32'(1) << m.own : 32'd0);
      cmp({p, ".bus_t"}, 32'(bt), m.own >= 0 ? 32'h00 : 32'hFF);
      cmp({p, ".bus_i"}, 32'(bi), m.own >= 0 ? 32'(m.bi) : 32'd0);
      cmp({p, ".busy"}, 32'(b), m.own >= 0 ? 32'd1 : 32'd0);
      if (m.own >= 0) cmp({p, ".owner"}, 32'(o), 32'(m.own));
   endtask
   always @(posedge CLK) begin
      m0 <= step(m0, RSTN, REQ, DIN, 16);
      m1 <= step(m1, RSTN, REQ, DIN, 1);
   end
   always @(negedge CLK) begin
      if (chk_en) begin
         chk_dut("u0", m0, g0, i0, t0, o0, b0);
         chk_dut("u1", m1, g1, i1, t1, o1, b1);
      end
   end
   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
      #2;
   endtask
   int n0, k, gap;
   logic pb;
   int exp_ord[5] = '{0, 1, 2, 3, 0};
   initial begin
      RSTN = 1'b0;
      REQ = 4'b1111;
      DIN = {8'h44, 8'hA5, 8'h22, 8'h11};
      for (int c = 0; c < 3; c++) begin
         cyc(1);
         chk_en = 1'b1;
         cmp("rst_gnt", 32'(g0), 32'd0);
         cmp("rst_bus_t", 32'(t0), 32'hFF);
         cmp("rst_bus_i", 32'(i0), 32'd0);
         cmp("rst_busy", 32'(b0), 32'd0);
      end
      RSTN = 1'b1;
      REQ = 4'b0000;
      cyc(4);
      REQ = 4'b0100;
      cyc(1);
      cmp("single_gnt", 32'(g0), 32'h4);
      cmp("single_bus_t", 32'(t0), 32'h00);
      cmp("single_bus_i", 32'(i0), 32'hA5);
      cmp("single_owner", 32'(o0), 32'd2);
      DIN[23:16] = 8'h5A;
      cyc(1);
      cmp("single_latency", 32'(i0), 32'h5A);
      cyc(2);
      REQ = 4'b0000;
      cyc(1);
      cmp("single_rel_t", 32'(t0), 32'hFF);
      cmp("single_rel_gnt", 32'(g0), 32'd0);
      cyc(4);
      REQ = 4'b0011;
      cyc(1);
      cmp("turn_first", 32'(g0), 32'h1);
      cyc(2);
      REQ = 4'b0010;
      cyc(1);
      cmp("turn_gap1", 32'(t0), 32'hFF);
      cyc(1);
      cmp("turn_gap2", 32'(t0), 32'hFF);
      cyc(1);
      cmp("turn_next", 32'(g0), 32'h2);
      REQ = 4'b0000;
      cyc(5);
      REQ = 4'b0001;
      n0 = 0;
      cyc(1);
      while (g0 == 4'b0001 && n0 < 50) begin
         n0++;
         if (n0 == 5) REQ = 4'b1001;
         cyc(1);
      end
      cmp("preempt_hold", 32'(n0), 32'd16);
      cmp("preempt_gap1", 32'(t0), 32'hFF);
      cyc(1);
      cmp("preempt_gap2", 32'(t0), 32'hFF);
      cyc(1);
      cmp("preempt_next", 32'(g0), 32'h8);
      cyc(2);
      REQ = 4'b0001;
      cyc(1);
      cmp("regrant_rel", 32'(t0), 32'hFF);
      cyc(2);
      cmp("regrant_gnt", 32'(g0), 32'h1);
      REQ = 4'b0000;
      cyc(4);
      RSTN = 1'b0;
      cyc(1);
      RSTN = 1'b1;
      REQ = 4'b1111;
      k = 0;
      gap = 0;
      pb = 1'b0;
      for (int c = 0; c < 30 && k < 5; c++) begin
         cyc(1);
         if (b1) begin
            if (!pb) begin
               cmp("fair_order", 32'(o1), 32'(exp_ord[k]));
               if (k > 0) cmp("fair_gap", 32'(gap), 32'd2);
               k++;
            end
            gap = 0;
         end else begin
            gap++;
         end
         pb = b1;
      end
      cmp("fair_count", 32'(k), 32'd5);
      REQ = 4'b0000;
      cyc(4);
      RSTN = 1'b0;
      cyc(1);
      RSTN = 1'b1;
      REQ = 4'b0010;
      cyc(1);
      cmp("mid_gnt", 32'(g0), 32'h2);
      cyc(2);
      RSTN = 1'b0;
      cyc(1);
      cmp("mid_rst_t", 32'(t0), 32'hFF);
      cmp("mid_rst_gnt", 32'(g0), 32'd0);
      RSTN = 1'b1;
      REQ = 4'b0011;
      cyc(1);
      cmp("mid_after", 32'(g0), 32'h1);
      REQ = 4'b0000;
      cyc(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
